// File: rtl/cache_miss_ctrl_pkg.sv
// Shared definitions for the cache miss controller: state encodings,
// RAM address-select codes and the word-counter width helper.
package cache_pkg;

  typedef enum logic [2:0] {
    NORMAL        = 3'd0,
    IC_MISS       = 3'd1,
    DC_MISS       = 3'd2,
    DC_MISS_D     = 3'd3,
    DOUBLE_MISS   = 3'd4,
    DOUBLE_MISS_D = 3'd5
  } miss_state_e;

  localparam logic [1:0] RAM_SEL_IC = 2'b00;
  localparam logic [1:0] RAM_SEL_DC = 2'b01;
  localparam logic [1:0] RAM_SEL_WB = 2'b11;

  function automatic int cnt_w(input int words);
    return (words <= 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/cache_miss_ctrl_if.sv
// Pipeline / cache / RAM signal bundle of the miss controller.
// master = controller side, slave = surrounding pipeline, caches and RAM.
interface cache_miss_ctrl_if #(
  parameter int CNT_W      = 3,
  parameter int WORD_BYTES = 4
) ();

  logic                  dc_read_in;
  logic                  dc_write_in;
  logic [CNT_W-1:0]      ic_word_sel_in;
  logic [CNT_W-1:0]      dc_word_sel_in;
  logic [WORD_BYTES-1:0] dc_byte_w_en_in;
  logic                  ic_hit_in;
  logic                  ic_valid_in;
  logic                  dc_hit_in;
  logic                  dc_valid_in;
  logic                  dc_dirty_in;
  logic                  ram_ready;

  logic                  ic_enable_out;
  logic                  ic_cmp_out;
  logic                  ic_write_out;
  logic                  ic_valid_out;
  logic [CNT_W-1:0]      ic_word_sel_out;
  logic [WORD_BYTES-1:0] ic_byte_w_en;
  logic                  dc_enable_out;
  logic                  dc_cmp_out;
  logic                  dc_write_out;
  logic                  dc_valid_out;
  logic [CNT_W-1:0]      dc_word_sel_out;
  logic [WORD_BYTES-1:0] dc_byte_w_en;
  logic [1:0]            ram_addr_sel;
  logic                  ram_en_out;
  logic                  ram_write_out;
  logic                  stall_out;
  logic [2:0]            status_out;

  modport master (
    input  dc_read_in, dc_write_in, ic_word_sel_in, dc_word_sel_in, dc_byte_w_en_in,
           ic_hit_in, ic_valid_in, dc_hit_in, dc_valid_in, dc_dirty_in, ram_ready,
    output ic_enable_out, ic_cmp_out, ic_write_out, ic_valid_out, ic_word_sel_out, ic_byte_w_en,
           dc_enable_out, dc_cmp_out, dc_write_out, dc_valid_out, dc_word_sel_out, dc_byte_w_en,
           ram_addr_sel, ram_en_out, ram_write_out, stall_out, status_out
  );

  modport slave (
    output dc_read_in, dc_write_in, ic_word_sel_in, dc_word_sel_in, dc_byte_w_en_in,
           ic_hit_in, ic_valid_in, dc_hit_in, dc_valid_in, dc_dirty_in, ram_ready,
    input  ic_enable_out, ic_cmp_out, ic_write_out, ic_valid_out, ic_word_sel_out, ic_byte_w_en,
           dc_enable_out, dc_cmp_out, dc_write_out, dc_valid_out, dc_word_sel_out, dc_byte_w_en,
           ram_addr_sel, ram_en_out, ram_write_out, stall_out, status_out
  );

endinterface

// File: rtl/cache_miss_ctrl_line_counter.sv
// Word counter for one line burst: synchronous clear, increment enable,
// saturates at the last word so it only wraps through an explicit clear.
module line_counter
  import cache_pkg::*;
#(
  parameter int WORDS_PER_LINE = 8,
  parameter int CNT_W          = cnt_w(WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && !last) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == LAST_WORD);

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss-handling controller for the split I/D cache pair with ram_ready burst handshake.
// Optional feature: define CACHE_IC_SNOOP_EN to source I-cache refill words from D-cache hits.
module cache_miss_ctrl
  import cache_pkg::*;
#(
  parameter int WORDS_PER_LINE = 8,
  parameter int WORD_BYTES     = 4,
  parameter int CNT_W          = cnt_w(WORDS_PER_LINE)
) (
  input  logic              clk,
  input  logic              reset,
  cache_miss_ctrl_if.master bus
);

  localparam logic [WORD_BYTES-1:0] BE_ALL = '1;

  miss_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last, cnt_clr, cnt_inc;
  logic             ic_miss, dc_miss, snoop_word, word_done;

  function automatic miss_state_e follow_on(input miss_state_e s);
    case (s)
      DC_MISS_D:     return DC_MISS;
      DOUBLE_MISS_D: return DOUBLE_MISS;
      DOUBLE_MISS:   return DC_MISS;
      default:       return NORMAL;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= NORMAL;
    end else begin
      state <= state_nxt;
    end
  end

  line_counter #(
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .CNT_W         (CNT_W)
  ) u_line_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .last (cnt_last)
  );

  always_comb begin
    state_nxt  = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    snoop_word = 1'b0;
    ic_miss    = !(bus.ic_hit_in && bus.ic_valid_in);
    dc_miss    = (bus.dc_read_in || bus.dc_write_in) && !(bus.dc_hit_in && bus.dc_valid_in);

    bus.ic_enable_out   = 1'b0;
    bus.ic_cmp_out      = 1'b0;
    bus.ic_write_out    = 1'b0;
    bus.ic_valid_out    = 1'b0;
    bus.ic_word_sel_out = cnt;
    bus.ic_byte_w_en    = '0;
    bus.dc_enable_out   = 1'b0;
    bus.dc_cmp_out      = 1'b0;
    bus.dc_write_out    = 1'b0;
    bus.dc_valid_out    = 1'b0;
    bus.dc_word_sel_out = cnt;
    bus.dc_byte_w_en    = '0;
    bus.ram_addr_sel    = RAM_SEL_IC;
    bus.ram_en_out      = 1'b0;
    bus.ram_write_out   = 1'b0;
    bus.stall_out       = 1'b1;
    bus.status_out      = state;

    case (state)
      NORMAL: begin
        bus.ic_enable_out   = 1'b1;
        bus.ic_cmp_out      = 1'b1;
        bus.ic_word_sel_out = bus.ic_word_sel_in;
        bus.dc_enable_out   = bus.dc_read_in || bus.dc_write_in;
        bus.dc_cmp_out      = 1'b1;
        bus.dc_write_out    = bus.dc_write_in;
        bus.dc_valid_out    = 1'b1;
        bus.dc_word_sel_out = bus.dc_word_sel_in;
        bus.dc_byte_w_en    = bus.dc_byte_w_en_in;
        bus.stall_out       = ic_miss || dc_miss;
        // A dirty victim is always written back before any refill starts
        if (dc_miss) begin
          cnt_clr = 1'b1;
          if (ic_miss) state_nxt = bus.dc_dirty_in ? DOUBLE_MISS_D : DOUBLE_MISS;
          else         state_nxt = bus.dc_dirty_in ? DC_MISS_D : DC_MISS;
        end else if (ic_miss) begin
          cnt_clr   = 1'b1;
          state_nxt = IC_MISS;
        end
      end
      IC_MISS, DOUBLE_MISS: begin
        bus.ic_enable_out = 1'b1;
        bus.ic_write_out  = 1'b1;
        bus.ic_valid_out  = 1'b1;
        bus.ic_byte_w_en  = BE_ALL;
        bus.dc_cmp_out    = 1'b1;
`ifdef CACHE_IC_SNOOP_EN
        bus.dc_enable_out = 1'b1;
        snoop_word        = bus.dc_hit_in && bus.dc_valid_in;
`endif
        bus.ram_addr_sel  = RAM_SEL_IC;
        bus.ram_en_out    = !snoop_word;
      end
      DC_MISS: begin
        bus.dc_enable_out = 1'b1;
        bus.dc_write_out  = 1'b1;
        bus.dc_valid_out  = 1'b1;
        bus.dc_byte_w_en  = BE_ALL;
        bus.ram_addr_sel  = RAM_SEL_DC;
        bus.ram_en_out    = 1'b1;
      end
      DC_MISS_D, DOUBLE_MISS_D: begin
        bus.dc_enable_out = 1'b1;
        bus.ram_addr_sel  = RAM_SEL_WB;
        bus.ram_en_out    = 1'b1;
        bus.ram_write_out = 1'b1;
      end
      default: begin
        state_nxt = NORMAL;
      end
    endcase

    // ram_ready without ram_en (e.g. in NORMAL) never completes a word
    word_done = (bus.ram_en_out && bus.ram_ready) || snoop_word;
    if (word_done && cnt_last) begin
      cnt_clr   = 1'b1;
      state_nxt = follow_on(state);
    end else if (word_done) begin
      cnt_inc = 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench for cache_miss_ctrl: directed scenarios plus randomized
// miss traffic against a phase-queue model of the line bursts.
module tb_cache_miss_ctrl;
  import cache_pkg::*;

`ifdef CACHE_IC_SNOOP_EN
  localparam bit SNOOP_BUILD = 1'b1;
`else
  localparam bit SNOOP_BUILD = 1'b0;
`endif

  localparam int PH_WB = 0;
  localparam int PH_IC = 1;
  localparam int PH_DC = 2;

  // Field order: stall, status, ram_en, ram_write, ram_sel, ic_en, ic_cmp, ic_write,
  // ic_sel, ic_be, dc_en, dc_cmp, dc_write, dc_sel, dc_be
  localparam logic [27:0] MASK_N = {1'b1, 3'h7, 2'b11, 2'b00, 3'b111, 3'h7, 4'h0,
                                    1'b1, 1'b0, 1'b1, 3'h7, 4'hF};

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cache_miss_ctrl_if #(.CNT_W(3), .WORD_BYTES(4)) bus8 ();
  cache_miss_ctrl_if #(.CNT_W(2), .WORD_BYTES(4)) bus4 ();

  cache_miss_ctrl #(.WORDS_PER_LINE(8), .WORD_BYTES(4)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8.master));
  cache_miss_ctrl #(.WORDS_PER_LINE(4), .WORD_BYTES(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.master));

  function automatic logic [27:0] obs8();
    return {bus8.stall_out, bus8.status_out, bus8.ram_en_out, bus8.ram_write_out, bus8.ram_addr_sel,
            bus8.ic_enable_out, bus8.ic_cmp_out, bus8.ic_write_out, bus8.ic_word_sel_out, bus8.ic_byte_w_en,
            bus8.dc_enable_out, bus8.dc_cmp_out, bus8.dc_write_out, bus8.dc_word_sel_out, bus8.dc_byte_w_en};
  endfunction

  task automatic idle8();
    bus8.dc_read_in = 0; bus8.dc_write_in = 0; bus8.ic_word_sel_in = '0; bus8.dc_word_sel_in = '0;
    bus8.dc_byte_w_en_in = '0; bus8.ic_hit_in = 1; bus8.ic_valid_in = 1; bus8.dc_hit_in = 0;
    bus8.dc_valid_in = 0; bus8.dc_dirty_in = 0; bus8.ram_ready = 0;
  endtask

  task automatic idle4();
    bus4.dc_read_in = 0; bus4.dc_write_in = 0; bus4.ic_word_sel_in = '0; bus4.dc_word_sel_in = '0;
    bus4.dc_byte_w_en_in = '0; bus4.ic_hit_in = 1; bus4.ic_valid_in = 1; bus4.dc_hit_in = 0;
    bus4.dc_valid_in = 0; bus4.dc_dirty_in = 0; bus4.ram_ready = 0;
  endtask

  task automatic test_reset();
    logic [27:0] exp;
    @(negedge clk);
    reset = 1; idle8(); idle4();
    bus8.dc_read_in = 1; bus8.dc_hit_in = 1; bus8.dc_valid_in = 1;
    @(negedge clk); @(negedge clk); #1;
    exp = {1'b0, NORMAL, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 3'd0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 4'h0};
    checks++;
    if ((obs8() & MASK_N) !== (exp & MASK_N)) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", obs8() & MASK_N, exp & MASK_N);
    end
    checks++;
    if ({bus4.stall_out, bus4.ram_en_out, bus4.status_out} !== {1'b0, 1'b0, 3'(NORMAL)}) begin
      errors++; $display("FAIL reset_wpl4: got %b expected %b",
                         {bus4.stall_out, bus4.ram_en_out, bus4.status_out}, {1'b0, 1'b0, 3'(NORMAL)});
    end
    @(negedge clk); reset = 0; idle8();
  endtask

  task automatic test_ic_miss();
    @(negedge clk);
    idle8(); bus8.ic_hit_in = 0; bus8.ram_ready = 1; bus8.ic_word_sel_in = 3'd5;
    #1; checks++;
    if ({bus8.stall_out, bus8.status_out} !== {1'b1, 3'(NORMAL)}) begin
      errors++; $display("FAIL ic_miss_detect: got %b expected %b", {bus8.stall_out, bus8.status_out}, {1'b1, 3'(NORMAL)});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); bus8.ic_hit_in = 1; #1; checks++;
      if ({bus8.stall_out, bus8.ic_write_out, bus8.ic_word_sel_out, bus8.status_out} !== {1'b1, 1'b1, 3'(i), 3'(IC_MISS)}) begin
        errors++; $display("FAIL ic_miss_word%0d: got %b expected %b", i,
                           {bus8.stall_out, bus8.ic_write_out, bus8.ic_word_sel_out, bus8.status_out},
                           {1'b1, 1'b1, 3'(i), 3'(IC_MISS)});
      end
    end
    @(negedge clk); #1; checks++;
    if ({bus8.stall_out, bus8.status_out} !== {1'b0, 3'(NORMAL)}) begin
      errors++; $display("FAIL ic_miss_end: got %b expected %b", {bus8.stall_out, bus8.status_out}, {1'b0, 3'(NORMAL)});
    end
  endtask

  task automatic test_dirty_dc();
    int stall_cnt = 0;
    int words = 0;
    logic [6:0] exp;
    @(negedge clk);
    idle8(); bus8.dc_read_in = 1; bus8.dc_valid_in = 1; bus8.dc_dirty_in = 1;
    #1; checks++;
    if (bus8.stall_out !== 1'b1) begin
      errors++; $display("FAIL dirty_dc_detect: got %b expected 1", bus8.stall_out);
    end
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk); bus8.dc_read_in = 0; bus8.ram_ready = (cyc % 2 == 1); #1;
      if (!bus8.stall_out) break;
      stall_cnt++;
      if (bus8.ram_ready) begin
        exp = (words < 8) ? {2'b11, 1'b1, 3'(words), 1'b0} : {2'b01, 1'b0, 3'(words), 1'b1};
        checks++;
        if ({bus8.ram_addr_sel, bus8.ram_write_out, bus8.dc_word_sel_out, bus8.dc_write_out} !== exp) begin
          errors++; $display("FAIL dirty_dc_word%0d: got %b expected %b", words,
                             {bus8.ram_addr_sel, bus8.ram_write_out, bus8.dc_word_sel_out, bus8.dc_write_out}, exp);
        end
        words++;
      end else begin
        checks++;
        if (bus8.dc_word_sel_out !== 3'(words)) begin
          errors++; $display("FAIL dirty_dc_hold: got %0d expected %0d", bus8.dc_word_sel_out, words % 8);
        end
      end
    end
    checks++;
    if (stall_cnt != 32 || words != 16) begin
      errors++; $display("FAIL dirty_dc_len: got %0d stalls %0d words expected 32 stalls 16 words", stall_cnt, words);
    end
  endtask

  task automatic test_double_dirty();
    miss_state_e st;
    @(negedge clk);
    idle8(); bus8.ic_hit_in = 0; bus8.dc_write_in = 1; bus8.dc_valid_in = 1;
    bus8.dc_dirty_in = 1; bus8.ram_ready = 1;
    #1; checks++;
    if (bus8.stall_out !== 1'b1) begin
      errors++; $display("FAIL double_detect: got %b expected 1", bus8.stall_out);
    end
    for (int i = 0; i < 24; i++) begin
      @(negedge clk); bus8.ic_hit_in = 1; bus8.dc_write_in = 0; #1;
      st = (i < 8) ? DOUBLE_MISS_D : (i < 16) ? DOUBLE_MISS : DC_MISS;
      checks++;
      if ({bus8.stall_out, bus8.status_out, bus8.dc_word_sel_out} !== {1'b1, 3'(st), 3'(i % 8)}) begin
        errors++; $display("FAIL double_cycle%0d: got %b expected %b", i,
                           {bus8.stall_out, bus8.status_out, bus8.dc_word_sel_out}, {1'b1, 3'(st), 3'(i % 8)});
      end
    end
    @(negedge clk); #1; checks++;
    if ({bus8.stall_out, bus8.status_out} !== {1'b0, 3'(NORMAL)}) begin
      errors++; $display("FAIL double_end: got %b expected %b", {bus8.stall_out, bus8.status_out}, {1'b0, 3'(NORMAL)});
    end
  endtask

  task automatic test_snoop();
    @(negedge clk);
    idle8(); bus8.ic_hit_in = 0; bus8.dc_hit_in = 1; bus8.dc_valid_in = 1;
    #1; checks++;
    if (bus8.stall_out !== 1'b1) begin
      errors++; $display("FAIL snoop_detect: got %b expected 1", bus8.stall_out);
    end
`ifdef CACHE_IC_SNOOP_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); bus8.ic_hit_in = 1; #1; checks++;
      if ({bus8.ram_en_out, bus8.ic_word_sel_out, bus8.status_out} !== {1'b0, 3'(i), 3'(IC_MISS)}) begin
        errors++; $display("FAIL snoop_word%0d: got %b expected %b", i,
                           {bus8.ram_en_out, bus8.ic_word_sel_out, bus8.status_out}, {1'b0, 3'(i), 3'(IC_MISS)});
      end
    end
`else
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); bus8.ic_hit_in = 1; #1; checks++;
      if ({bus8.ram_en_out, bus8.ic_word_sel_out, bus8.status_out} !== {1'b1, 3'd0, 3'(IC_MISS)}) begin
        errors++; $display("FAIL snoop_off_wait%0d: got %b expected %b", i,
                           {bus8.ram_en_out, bus8.ic_word_sel_out, bus8.status_out}, {1'b1, 3'd0, 3'(IC_MISS)});
      end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); bus8.ram_ready = 1; #1; checks++;
      if ({bus8.ram_en_out, bus8.ic_word_sel_out} !== {1'b1, 3'(i)}) begin
        errors++; $display("FAIL snoop_off_word%0d: got %b expected %b", i,
                           {bus8.ram_en_out, bus8.ic_word_sel_out}, {1'b1, 3'(i)});
      end
    end
`endif
    @(negedge clk); bus8.ram_ready = 0; #1; checks++;
    if ({bus8.stall_out, bus8.status_out} !== {1'b0, 3'(NORMAL)}) begin
      errors++; $display("FAIL snoop_end: got %b expected %b", {bus8.stall_out, bus8.status_out}, {1'b0, 3'(NORMAL)});
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    idle8(); bus8.dc_read_in = 1; bus8.dc_valid_in = 1; bus8.ram_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus8.dc_read_in = 0; #1;
    end
    checks++;
    if ({bus8.status_out, bus8.dc_word_sel_out} !== {3'(DC_MISS), 3'd3}) begin
      errors++; $display("FAIL rst_mid_pre: got %b expected %b", {bus8.status_out, bus8.dc_word_sel_out}, {3'(DC_MISS), 3'd3});
    end
    reset = 1;
    @(negedge clk); reset = 0; #1; checks++;
    if ({bus8.status_out, bus8.ram_en_out, bus8.stall_out} !== {3'(NORMAL), 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_mid_post: got %b expected %b",
                         {bus8.status_out, bus8.ram_en_out, bus8.stall_out}, {3'(NORMAL), 1'b0, 1'b0});
    end
  endtask

  task automatic test_wpl4();
    @(negedge clk);
    idle4(); bus4.dc_read_in = 1; bus4.dc_valid_in = 1; bus4.ram_ready = 1; bus4.dc_word_sel_in = 2'd3;
    #1; checks++;
    if (bus4.stall_out !== 1'b1) begin
      errors++; $display("FAIL wpl4_detect: got %b expected 1", bus4.stall_out);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus4.dc_read_in = 0; #1; checks++;
      if ({bus4.dc_word_sel_out, bus4.dc_write_out, bus4.status_out} !== {2'(i), 1'b1, 3'(DC_MISS)}) begin
        errors++; $display("FAIL wpl4_word%0d: got %b expected %b", i,
                           {bus4.dc_word_sel_out, bus4.dc_write_out, bus4.status_out}, {2'(i), 1'b1, 3'(DC_MISS)});
      end
    end
    @(negedge clk); #1; checks++;
    if ({bus4.stall_out, bus4.status_out} !== {1'b0, 3'(NORMAL)}) begin
      errors++; $display("FAIL wpl4_end: got %b expected %b", {bus4.stall_out, bus4.status_out}, {1'b0, 3'(NORMAL)});
    end
  endtask

  task automatic test_random();
    int ph_q[$];
    int word, budget, ph;
    bit icm, dcm, dbl, rd, wr, dirty, snoop;
    miss_state_e st;
    logic [1:0] sel_e;
    logic [27:0] exp, mask;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      idle8();
      bus8.ic_hit_in = ($urandom_range(0, 3) != 0); bus8.ic_valid_in = ($urandom_range(0, 3) != 0);
      rd = 1'($urandom_range(0, 1)); wr = !rd && ($urandom_range(0, 1) == 1);
      bus8.dc_read_in = rd; bus8.dc_write_in = wr;
      bus8.dc_hit_in = 1'($urandom_range(0, 1)); bus8.dc_valid_in = 1'($urandom_range(0, 1));
      dirty = 1'($urandom_range(0, 1)); bus8.dc_dirty_in = dirty;
      bus8.ic_word_sel_in = 3'($urandom); bus8.dc_word_sel_in = 3'($urandom); bus8.dc_byte_w_en_in = 4'($urandom);
      icm = !(bus8.ic_hit_in && bus8.ic_valid_in);
      dcm = (rd || wr) && !(bus8.dc_hit_in && bus8.dc_valid_in);
      dbl = icm && dcm;
      #1;
      exp = {icm || dcm, NORMAL, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, bus8.ic_word_sel_in, 4'h0,
             rd || wr, 1'b0, wr, bus8.dc_word_sel_in, bus8.dc_byte_w_en_in};
      checks++;
      if ((obs8() & MASK_N) !== (exp & MASK_N)) begin
        errors++; $display("FAIL rand_normal%0d: got %h expected %h", t, obs8() & MASK_N, exp & MASK_N);
      end
      ph_q = {};
      if (dcm && dirty) ph_q.push_back(PH_WB);
      if (icm)          ph_q.push_back(PH_IC);
      if (dcm)          ph_q.push_back(PH_DC);
      word = 0; budget = 0;
      while (ph_q.size() > 0 && budget < 400) begin
        @(negedge clk); budget++;
        bus8.ic_hit_in = 1; bus8.ic_valid_in = 1; bus8.dc_read_in = 0; bus8.dc_write_in = 0;
        bus8.ram_ready = ($urandom_range(0, 9) < 6);
        bus8.dc_hit_in = 1'($urandom_range(0, 1)); bus8.dc_valid_in = 1'($urandom_range(0, 1));
        ph = ph_q[0];
        snoop = SNOOP_BUILD && (ph == PH_IC) && bus8.dc_hit_in && bus8.dc_valid_in;
        st = (ph == PH_WB) ? (dbl ? DOUBLE_MISS_D : DC_MISS_D)
           : (ph == PH_IC) ? (dbl ? DOUBLE_MISS : IC_MISS) : DC_MISS;
        sel_e = (ph == PH_WB) ? RAM_SEL_WB : (ph == PH_IC) ? RAM_SEL_IC : RAM_SEL_DC;
        #1;
        exp = {1'b1, st, !snoop, ph == PH_WB, sel_e, ph == PH_IC, 1'b0, ph == PH_IC, 3'(word),
               (ph == PH_IC) ? 4'hF : 4'h0, (ph != PH_IC) || SNOOP_BUILD, ph == PH_IC, ph == PH_DC,
               3'(word), (ph == PH_DC) ? 4'hF : 4'h0};
        mask = {8'hFF, ph != PH_DC, ph == PH_IC, 18'h3FFFF};
        checks++;
        if ((obs8() & mask) !== (exp & mask)) begin
          errors++; $display("FAIL rand_burst%0d_ph%0d_w%0d: got %h expected %h", t, ph, word, obs8() & mask, exp & mask);
        end
        if (snoop || bus8.ram_ready) begin
          word++;
          if (word == 8) begin
            word = 0;
            void'(ph_q.pop_front());
          end
        end
      end
      if (ph_q.size() > 0) begin
        checks++; errors++;
        $display("FAIL rand_timeout%0d: got %0d phases left expected 0", t, ph_q.size());
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1; idle8(); idle4();
    test_reset();
    test_ic_miss();
    test_dirty_dc();
    test_double_dirty();
    test_snoop();
    test_wpl4();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
